// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage pipelined immediate/label extender (sext, zext,
// sext<<SHIFT, pc+sext) with valid/ready back-pressure and synchronous flush.
module imm_extend_pipe #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [OUT_W-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        MODE_SEXT     = 2'b00,
        MODE_ZEXT     = 2'b01,
        MODE_SEXT_SHL = 2'b10,
        MODE_PC_REL   = 2'b11
    } mode_e;

    localparam int EXT_W = OUT_W - IN_W;

    logic             s1_valid_q, s1_valid_d;
    mode_e            s1_mode_q,  s1_mode_d;
    logic [OUT_W-1:0] s1_pc_q,    s1_pc_d;
    logic [OUT_W-1:0] s1_ext_q,   s1_ext_d;

    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] s2_data_q,  s2_data_d;
    logic             s2_ovf_q,   s2_ovf_d;

    logic             s2_free;
    logic             s1_advance;
    logic             in_xfer;
    mode_e            in_mode_e;
    logic [OUT_W-1:0] in_ext;
    logic [OUT_W:0]   pc_sum;
    logic [OUT_W-1:0] s2_result;
    logic             s2_ovf_calc;

    // Only flush, out_ready and rst_n reach in_ready combinationally.
    always_comb begin
        s2_free    = !s2_valid_q || out_ready;
        s1_advance = s1_valid_q && s2_free;
        in_ready   = rst_n && !flush && (!s1_valid_q || s2_free);
        in_xfer    = in_valid && in_ready;
    end

    always_comb begin
        in_mode_e = mode_e'(in_mode);
        if (in_mode_e == MODE_ZEXT) begin
            in_ext = {{EXT_W{1'b0}}, in_imm};
        end else begin
            in_ext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold default first, so no path through
        // this block can leave a value unassigned and infer a latch.
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_pc_d    = s1_pc_q;
        s1_ext_d   = s1_ext_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = in_mode_e;
            s1_pc_d    = in_pc;
            s1_ext_d   = in_ext;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // The extra top bit of pc_sum catches a target wrapping past either end.
    always_comb begin
        pc_sum      = {1'b0, s1_pc_q} + {s1_ext_q[OUT_W-1], s1_ext_q};
        s2_result   = s1_ext_q;
        s2_ovf_calc = 1'b0;
        case (s1_mode_q)
            MODE_SEXT_SHL: s2_result = s1_ext_q << SHIFT;
            MODE_PC_REL: begin
                s2_result   = pc_sum[OUT_W-1:0];
                s2_ovf_calc = pc_sum[OUT_W];
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_advance) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s2_result;
            s2_ovf_d   = s2_ovf_calc;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // NOTE: the datapath registers are reset as well, because out_data and
    // out_ovf must read 0 while rst_n is low, not just out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_SEXT;
            s1_pc_q    <= '0;
            s1_ext_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking, so S2 captures the pre-edge S1 contents
            // even though S1 reloads on the same edge.
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_pc_q    <= s1_pc_d;
            s1_ext_q   <= s1_ext_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;

endmodule
